ikbd_matrix_scanner: RTL and testbench

//  Scans the 15x8 active-low ST key matrix (driven by the PS/2 decoder) position by position.

---
 rtl/ikbd_pkg.sv | 34 +++
 rtl/ikbd_matrix_scanner_if.sv | 11 +
 rtl/ikbd_event_fifo.sv | 80 ++++++++
 rtl/ikbd_matrix_scanner.sv | 131 +++++++++++++
 tb/tb_ikbd_matrix_scanner.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ikbd_pkg.sv
// Shared constants, types and the ST keyboard matrix scancode table for the IKBD matrix scanner.
package ikbd_pkg;

   localparam int unsigned NUM_COLS = 15;
   localparam int unsigned NUM_ROWS = 8;
   localparam int unsigned NUM_KEYS = NUM_COLS * NUM_ROWS;
   localparam int unsigned COL_W    = 4;
   localparam int unsigned ROW_W    = 3;

   typedef logic [7:0] ikbd_event_t;
   typedef logic [NUM_COLS-1:0][NUM_ROWS-1:0] ikbd_matrix_t;

   localparam ikbd_event_t BREAK_BIT = 8'h80;

   // Indexed [col][row]; 8'h00 marks a position with no key fitted.
   localparam ikbd_event_t ST_SCANCODE [NUM_COLS][NUM_ROWS] = '{
      '{8'h00, 8'h3B, 8'h3C, 8'h3D, 8'h3E, 8'h3F, 8'h40, 8'h41},
      '{8'h42, 8'h43, 8'h44, 8'h01, 8'h0F, 8'h2A, 8'h1D, 8'h38},
      '{8'h02, 8'h03, 8'h10, 8'h11, 8'h2C, 8'h2D, 8'h00, 8'h00},
      '{8'h04, 8'h05, 8'h12, 8'h13, 8'h2E, 8'h2F, 8'h1F, 8'h20},
      '{8'h06, 8'h07, 8'h14, 8'h15, 8'h30, 8'h1E, 8'h21, 8'h22},
      '{8'h08, 8'h09, 8'h16, 8'h17, 8'h31, 8'h32, 8'h23, 8'h24},
      '{8'h0A, 8'h0B, 8'h18, 8'h19, 8'h33, 8'h34, 8'h25, 8'h26},
      '{8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h35, 8'h36, 8'h27, 8'h28},
      '{8'h0E, 8'h29, 8'h2B, 8'h1C, 8'h53, 8'h47, 8'h00, 8'h00},
      '{8'h62, 8'h61, 8'h52, 8'h3A, 8'h60, 8'h00, 8'h00, 8'h39},
      '{8'h63, 8'h64, 8'h65, 8'h66, 8'h4A, 8'h4E, 8'h00, 8'h00},
      '{8'h67, 8'h68, 8'h69, 8'h6A, 8'h6B, 8'h6C, 8'h00, 8'h00},
      '{8'h4B, 8'h48, 8'h50, 8'h4D, 8'h6D, 8'h6E, 8'h6F, 8'h00},
      '{8'h70, 8'h71, 8'h72, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
      '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
   };

endpackage

// File: rtl/ikbd_matrix_scanner_if.sv
// Make/break event stream from the matrix scanner to the IKBD serial transmit path.
interface ikbd_matrix_scanner_if;
   import ikbd_pkg::*;

   logic        valid;
   ikbd_event_t data;
   logic        ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ikbd_event_fifo.sv
// First-word-fall-through event FIFO; head, fill, full and empty are all registered.
module ikbd_event_fifo
   import ikbd_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  ikbd_event_t              din,
   input  logic                     pop,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   fill,
   output ikbd_event_t              head
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   ikbd_event_t   mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_nxt;
   logic [AW-1:0] wr_nxt;
   logic [CW-1:0] count_nxt;
   logic          do_push;
   logic          do_pop;
   ikbd_event_t   head_nxt;

   // Flush wins over push/pop; a push into a full FIFO succeeds only alongside a pop.
   always_comb begin
      do_pop    = pop && !empty && !flush;
      do_push   = push && !flush && (!full || do_pop);
      rd_nxt    = do_pop  ? rd_ptr + 1'b1 : rd_ptr;
      wr_nxt    = do_push ? wr_ptr + 1'b1 : wr_ptr;
      count_nxt = fill;
      if (flush) begin
         rd_nxt    = '0;
         wr_nxt    = '0;
         count_nxt = '0;
      end else if (do_push && !do_pop) begin
         count_nxt = fill + 1'b1;
      end else if (do_pop && !do_push) begin
         count_nxt = fill - 1'b1;
      end
      // Next head bypasses the write when the pushed word lands in the head slot.
      if (count_nxt == '0)
         head_nxt = '0;
      else if (do_push && (wr_ptr == rd_nxt))
         head_nxt = din;
      else
         head_nxt = mem[rd_nxt];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         fill   <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
         head   <= '0;
      end else begin
         rd_ptr <= rd_nxt;
         wr_ptr <= wr_nxt;
         fill   <= count_nxt;
         empty  <= (count_nxt == '0);
         full   <= (count_nxt == FULL_CNT);
         head   <= head_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ikbd_matrix_scanner.sv
// Lossless ST key matrix scanner emitting make/break scancodes into an event FIFO.
// Optional IKBD_SCAN_DEBOUNCE_EN requires a change to be seen on two consecutive visits.
module ikbd_matrix_scanner
   import ikbd_pkg::*;
#(
   parameter int unsigned SCAN_DIV   = 16,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  ikbd_matrix_t                  matrix,
   input  logic                          scan_en,
   input  logic                          flush,
   ikbd_matrix_scanner_if.master         ev,
   output logic                          stalled,
   output logic [$clog2(FIFO_DEPTH):0]   fill
);
   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   ikbd_matrix_t     shadow;

   logic        scan_tick;
   logic        cur;
   logic        sh;
   ikbd_event_t code;
   logic        changed;
   logic        mapped;
   logic        confirmed;
   logic        report;
   logic        pop;
   logic        can_push;
   logic        push;
   logic        blocked;
   ikbd_event_t ev_word;
   logic        fifo_full;
   logic        fifo_empty;
   ikbd_event_t fifo_head;

`ifdef IKBD_SCAN_DEBOUNCE_EN
   logic [NUM_KEYS-1:0]    pending;
   logic [COL_W+ROW_W-1:0] key_idx;
   assign key_idx = {col, row};
`endif

   // A stalled position retries every clock instead of waiting for the divider.
   always_comb begin
      scan_tick = scan_en && (stalled || (div_cnt == DIV_LAST));
      cur       = matrix[col][row];
      sh        = shadow[col][row];
      code      = ST_SCANCODE[col][row];
      changed   = (cur != sh);
      mapped    = (code != 8'h00);
`ifdef IKBD_SCAN_DEBOUNCE_EN
      confirmed = pending[key_idx];
`else
      confirmed = 1'b1;
`endif
      report    = scan_tick && changed && mapped && confirmed;
      pop       = ev.valid && ev.ready;
      can_push  = !flush && (!fifo_full || pop);
      push      = report && can_push;
      blocked   = report && !can_push;
      ev_word   = cur ? (code | BREAK_BIT) : code;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         col     <= '0;
         row     <= '0;
         shadow  <= '1;
         stalled <= 1'b0;
      end else begin
         if (scan_en && !stalled)
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
         if (scan_tick) begin
            stalled <= blocked;
            // The pointer only moves once the visit is fully resolved.
            if (!blocked) begin
               if (row == ROW_LAST) begin
                  row <= '0;
                  col <= (col == COL_LAST) ? '0 : col + 1'b1;
               end else begin
                  row <= row + 1'b1;
               end
            end
            if (changed && (!mapped || push))
               shadow[col][row] <= cur;
         end
      end
   end

`ifdef IKBD_SCAN_DEBOUNCE_EN
   // First mismatching visit only arms the position; a matching visit disarms it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
      end else if (scan_tick) begin
         if (!changed || !mapped || push)
            pending[key_idx] <= 1'b0;
         else if (!pending[key_idx])
            pending[key_idx] <= 1'b1;
      end
   end
`endif

   ikbd_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (ev_word),
      .pop   (pop),
      .flush (flush),
      .full  (fifo_full),
      .empty (fifo_empty),
      .fill  (fill),
      .head  (fifo_head)
   );

   assign ev.valid = !fifo_empty;
   assign ev.data  = fifo_head;

endmodule

// File: tb/tb_ikbd_matrix_scanner.sv
// Directed self-checking bench for ikbd_matrix_scanner (SCAN_DIV=1, FIFO_DEPTH=8).
// Covers IKBD_SCAN_DEBOUNCE_EN behaviour when the macro is defined.
module tb_ikbd_matrix_scanner;
   import ikbd_pkg::*;

   localparam int unsigned PASS = 120;
   localparam int unsigned WAIT = 400;

   logic         clk = 1'b0;
   logic         reset;
   ikbd_matrix_t mat;
   logic         scan_en;
   logic         flush;
   logic         stalled;
   logic [3:0]   fill;

   ikbd_matrix_scanner_if ev_if ();

   ikbd_matrix_scanner #(
      .SCAN_DIV   (1),
      .FIFO_DEPTH (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .matrix  (mat),
      .scan_en (scan_en),
      .flush   (flush),
      .ev      (ev_if),
      .stalled (stalled),
      .fill    (fill)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   ikbd_event_t got [$];

   // Every accepted event, in order.
   always @(posedge clk)
      if (!reset && ev_if.valid && ev_if.ready)
         got.push_back(ev_if.data);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] got_at(input int i);
      return (i < got.size()) ? 32'(got[i]) : 32'hDEAD;
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   ikbd_event_t exp_fill9 [9] = '{8'h04, 8'h05, 8'h12, 8'h13, 8'h2E, 8'h2F, 8'h1F, 8'h20, 8'h48};

   initial begin
      reset       = 1'b1;
      mat         = '1;
      scan_en     = 1'b1;
      flush       = 1'b0;
      ev_if.ready = 1'b0;
      cycles(3);
      check("rst_valid",   32'(ev_if.valid), 32'h0);
      check("rst_data",    32'(ev_if.data),  32'h0);
      check("rst_stalled", 32'(stalled),     32'h0);
      check("rst_fill",    32'(fill),        32'h0);
      reset = 1'b0;
      ev_if.ready = 1'b1;
      cycles(WAIT);
      check("idle_events", 32'(got.size()), 32'd0);

      // Make and break of A.
      mat[4][5] = 1'b0;
      cycles(WAIT);
      check("a_make_cnt", 32'(got.size()), 32'd1);
      check("a_make",     got_at(0),       32'h1E);
      got.delete();
      mat[4][5] = 1'b1;
      cycles(WAIT);
      check("a_break_cnt", 32'(got.size()), 32'd1);
      check("a_break",     got_at(0),       32'h9E);
      got.delete();

      // Unmapped position is silent; space still reports.
      mat[0][0] = 1'b0;
      cycles(WAIT);
      check("unmapped_cnt", 32'(got.size()), 32'd0);
      mat[9][7] = 1'b0;
      cycles(WAIT);
      check("space_cnt", 32'(got.size()), 32'd1);
      check("space",     got_at(0),       32'h39);
      got.delete();
      mat[0][0] = 1'b1;
      mat[9][7] = 1'b1;
      cycles(WAIT);
      check("space_brk_cnt", 32'(got.size()), 32'd1);
      check("space_brk",     got_at(0),       32'hB9);
      got.delete();

      // Nine presses into a stopped consumer: eight queued, ninth stalls.
      ev_if.ready = 1'b0;
      for (int r = 0; r < 8; r++) mat[3][r] = 1'b0;
      mat[12][1] = 1'b0;
      cycles(WAIT);
      check("full_fill",    32'(fill),        32'd8);
      check("full_stalled", 32'(stalled),     32'h1);
      check("full_head",    32'(ev_if.data),  32'h04);
      ev_if.ready = 1'b1;
      cycles(1);
      ev_if.ready = 1'b0;
      check("poppush_fill",    32'(fill),    32'd8);
      check("poppush_stalled", 32'(stalled), 32'h0);
      check("poppush_head",    32'(ev_if.data), 32'h05);
      ev_if.ready = 1'b1;
      cycles(30);
      check("drain_cnt", 32'(got.size()), 32'd9);
      for (int i = 0; i < 9; i++)
         check($sformatf("drain_%0d", i), got_at(i), 32'(exp_fill9[i]));
      check("drain_valid", 32'(ev_if.valid), 32'h0);
      check("drain_data",  32'(ev_if.data),  32'h0);
      check("drain_fill",  32'(fill),        32'd0);
      got.delete();

      // Flush five queued breaks; they must not be reported again.
      ev_if.ready = 1'b0;
      for (int r = 0; r < 5; r++) mat[3][r] = 1'b1;
      cycles(WAIT);
      check("pre_flush_fill", 32'(fill), 32'd5);
      flush = 1'b1;
      cycles(1);
      flush = 1'b0;
      check("flush_valid", 32'(ev_if.valid), 32'h0);
      check("flush_fill",  32'(fill),        32'd0);
      ev_if.ready = 1'b1;
      cycles(WAIT);
      check("flush_no_rereport", 32'(got.size()), 32'd0);
      got.delete();

      // Reset while stalled.
      ev_if.ready = 1'b0;
      for (int r = 5; r < 8; r++) mat[3][r] = 1'b1;
      mat[12][1] = 1'b1;
      for (int r = 0; r < 8; r++) mat[5][r] = 1'b0;
      mat[6][0] = 1'b0;
      cycles(WAIT);
      check("stall2_stalled", 32'(stalled), 32'h1);
      check("stall2_fill",    32'(fill),    32'd8);
      reset = 1'b1;
      #1;
      check("mid_rst_valid",   32'(ev_if.valid), 32'h0);
      check("mid_rst_data",    32'(ev_if.data),  32'h0);
      check("mid_rst_stalled", 32'(stalled),     32'h0);
      check("mid_rst_fill",    32'(fill),        32'h0);
      cycles(2);
      reset = 1'b0;
      ev_if.ready = 1'b1;
      cycles(WAIT);
      check("post_rst_cnt",   32'(got.size()), 32'd9);
      check("post_rst_first", got_at(0),       32'h08);
      check("post_rst_last",  got_at(8),       32'h0A);
      for (int r = 0; r < 8; r++) mat[5][r] = 1'b1;
      mat[6][0] = 1'b1;
      cycles(WAIT);
      got.delete();

`ifdef IKBD_SCAN_DEBOUNCE_EN
      // One-visit glitch is filtered; a held press reports within two passes.
      mat[4][5] = 1'b0;
      cycles(PASS);
      mat[4][5] = 1'b1;
      cycles(WAIT);
      check("glitch_cnt", 32'(got.size()), 32'd0);
      mat[4][5] = 1'b0;
      cycles(2 * PASS + 5);
      check("held_cnt", 32'(got.size()), 32'd1);
      check("held",     got_at(0),       32'h1E);
      cycles(PASS - 5);
      mat[4][5] = 1'b1;
      cycles(WAIT);
      check("held_brk", got_at(1), 32'h9E);
`else
      // Without debounce a press reports within one pass.
      mat[4][5] = 1'b0;
      cycles(PASS + 3);
      check("fast_cnt", 32'(got.size()), 32'd1);
      check("fast",     got_at(0),       32'h1E);
      mat[4][5] = 1'b1;
      cycles(PASS + 3);
      check("fast_brk", got_at(1), 32'h9E);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
